// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcode constants, FSM state
// encodings, ALU/PC select codes and the packed control-output bundle. Also imported by the
// datapath and the ALU control decoder.
package multi_cycle_ctrl_pkg;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpAddi  = 6'b001000;

   localparam logic [1:0] AluOpAdd  = 2'b00;
   localparam logic [1:0] AluOpSub  = 2'b01;
   localparam logic [1:0] AluOpFunc = 2'b10;

   localparam logic [1:0] SrcBReg   = 2'b00;
   localparam logic [1:0] SrcBFour  = 2'b01;
   localparam logic [1:0] SrcBImm   = 2'b10;
   localparam logic [1:0] SrcBImmSh = 2'b11;

   localparam logic [1:0] PcSrcAlu    = 2'b00;
   localparam logic [1:0] PcSrcAluOut = 2'b01;
   localparam logic [1:0] PcSrcJump   = 2'b10;

   typedef enum logic [3:0] {
      StIf   = 4'd0,
      StId   = 4'd1,
      StMadr = 4'd2,
      StMrd  = 4'd3,
      StMwb  = 4'd4,
      StMwr  = 4'd5,
      StRex  = 4'd6,
      StRwb  = 4'd7,
      StBeq  = 4'd8,
      StJmp  = 4'd9,
      StIex  = 4'd10,
      StIwb  = 4'd11
   } state_e;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       illegal;
   } ctrl_out_t;

   function automatic logic is_legal_op(input logic [5:0] op);
      return (op == OpRtype) || (op == OpLw) || (op == OpSw) ||
             (op == OpBeq) || (op == OpJ) || (op == OpAddi);
   endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Controller <-> datapath bundle.
//   Op, mem_ready          : datapath -> controller (opcode field, memory done)
//   PCWrite .. PCSource    : controller -> datapath control strobes and selects
//   illegal, state         : controller status (unsupported opcode pulse, debug state)
// master = controller side, slave = datapath side.
interface multi_cycle_ctrl_if;
   logic [5:0] Op;
   logic       mem_ready;
   logic       PCWrite;
   logic       PCWriteCond;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       MemtoReg;
   logic       RegDst;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUop;
   logic [1:0] PCSource;
   logic       illegal;
   logic [3:0] state;

   modport master (
      input  Op, mem_ready,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
             RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource, illegal, state
   );

   modport slave (
      output Op, mem_ready,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
             RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource, illegal, state
   );
endinterface

// File: rtl/ctrl_out_decode.sv
// Combinational state-to-control decoder.
//   state_i     : current FSM state
//   op_i        : opcode, used only to flag an illegal opcode in ID
//   mem_ready_i : effective memory-done, gates IRWrite/PCWrite in IF
//   rst_i       : forces every output low while reset is held
//   out_o       : decoded control bundle
module ctrl_out_decode
   import multi_cycle_ctrl_pkg::*;
(
   input  state_e     state_i,
   input  logic [5:0] op_i,
   input  logic       mem_ready_i,
   input  logic       rst_i,
   output ctrl_out_t  out_o
);

   always_comb begin
      out_o = '0;
      if (!rst_i) begin
         unique case (state_i)
            StIf: begin
               out_o.mem_read  = 1'b1;
               out_o.alu_src_b = SrcBFour;
               out_o.alu_op    = AluOpAdd;
               out_o.pc_source = PcSrcAlu;
               // IR and PC+4 commit only in the cycle the fetch completes
               out_o.ir_write  = mem_ready_i;
               out_o.pc_write  = mem_ready_i;
            end
            StId: begin
               out_o.alu_src_b = SrcBImmSh;
               out_o.alu_op    = AluOpAdd;
               out_o.illegal   = !is_legal_op(op_i);
            end
            StMadr, StIex: begin
               out_o.alu_src_a = 1'b1;
               out_o.alu_src_b = SrcBImm;
               out_o.alu_op    = AluOpAdd;
            end
            StMrd: begin
               out_o.mem_read = 1'b1;
               out_o.iord     = 1'b1;
            end
            StMwb: begin
               out_o.reg_write  = 1'b1;
               out_o.mem_to_reg = 1'b1;
            end
            StMwr: begin
               out_o.mem_write = 1'b1;
               out_o.iord      = 1'b1;
            end
            StRex: begin
               out_o.alu_src_a = 1'b1;
               out_o.alu_src_b = SrcBReg;
               out_o.alu_op    = AluOpFunc;
            end
            StRwb: begin
               out_o.reg_write = 1'b1;
               out_o.reg_dst   = 1'b1;
            end
            StBeq: begin
               out_o.alu_src_a     = 1'b1;
               out_o.alu_src_b     = SrcBReg;
               out_o.alu_op        = AluOpSub;
               out_o.pc_write_cond = 1'b1;
               out_o.pc_source     = PcSrcAluOut;
            end
            StJmp: begin
               out_o.pc_write  = 1'b1;
               out_o.pc_source = PcSrcJump;
            end
            StIwb: begin
               out_o.reg_write = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS main controller: state register and next-state logic; control outputs
// come from ctrl_out_decode.
//   clk, rst : clock and synchronous active-high reset
//   bus      : controller side of multi_cycle_ctrl_if (opcode/mem_ready in, controls out)
//   MEM_WAIT : 1 = memory states wait for mem_ready, 0 = memory treated as always ready
module multi_cycle_ctrl
   import multi_cycle_ctrl_pkg::*;
#(
   parameter bit MEM_WAIT = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   multi_cycle_ctrl_if.master  bus
);

   state_e    state_q, state_d;
   logic      mem_rdy;
   ctrl_out_t ctrl;

   assign mem_rdy = MEM_WAIT ? bus.mem_ready : 1'b1;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIf:  if (mem_rdy) state_d = StId;
         StId: begin
            unique case (bus.Op)
               OpLw, OpSw: state_d = StMadr;
               OpRtype:    state_d = StRex;
               OpBeq:      state_d = StBeq;
               OpJ:        state_d = StJmp;
               OpAddi:     state_d = StIex;
               default:    state_d = StIf;
            endcase
         end
         // Op is re-examined here; anything other than lw/sw abandons the access
         StMadr: begin
            if (bus.Op == OpLw)      state_d = StMrd;
            else if (bus.Op == OpSw) state_d = StMwr;
            else                     state_d = StIf;
         end
         StMrd:  if (mem_rdy) state_d = StMwb;
         StMwr:  if (mem_rdy) state_d = StIf;
         StRex:  state_d = StRwb;
         StIex:  state_d = StIwb;
         StMwb, StRwb, StIwb, StBeq, StJmp: state_d = StIf;
         default: state_d = StIf;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= StIf;
      else     state_q <= state_d;
   end

   ctrl_out_decode u_decode (
      .state_i     (state_q),
      .op_i        (bus.Op),
      .mem_ready_i (mem_rdy),
      .rst_i       (rst),
      .out_o       (ctrl)
   );

   assign bus.PCWrite     = ctrl.pc_write;
   assign bus.PCWriteCond = ctrl.pc_write_cond;
   assign bus.IorD        = ctrl.iord;
   assign bus.MemRead     = ctrl.mem_read;
   assign bus.MemWrite    = ctrl.mem_write;
   assign bus.IRWrite     = ctrl.ir_write;
   assign bus.MemtoReg    = ctrl.mem_to_reg;
   assign bus.RegDst      = ctrl.reg_dst;
   assign bus.RegWrite    = ctrl.reg_write;
   assign bus.ALUSrcA     = ctrl.alu_src_a;
   assign bus.ALUSrcB     = ctrl.alu_src_b;
   assign bus.ALUop       = ctrl.alu_op;
   assign bus.PCSource    = ctrl.pc_source;
   assign bus.illegal     = ctrl.illegal;
   assign bus.state       = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: the stimulus process expands each instruction into
// its expected cycle-by-cycle phase sequence and pushes the expected output vector; a monitor
// pops and compares one vector every cycle at the falling edge.
module tb_multi_cycle_ctrl;
   import multi_cycle_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   multi_cycle_ctrl_if bus_if ();

   multi_cycle_ctrl #(.MEM_WAIT(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,
   //  ALUSrcB[2],ALUop[2],PCSource[2],illegal,state[4]}
   logic [20:0] exp_q[$];
   string       name_q[$];
   int          checks = 0;
   int          failures = 0;

   function automatic bit legal(input logic [5:0] op);
      return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
   endfunction

   function automatic logic [20:0] exp_vec(input state_e st, input bit rdy, input bit ill,
                                           input bit r);
      logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rdst = 0;
      logic rw = 0, srca = 0, illo = 0;
      logic [1:0] srcb = 2'b00, aop = 2'b00, pcs = 2'b00;
      if (!r) begin
         case (st)
            StIf:   begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            StId:   begin srcb = 2'b11; illo = ill; end
            StMadr: begin srca = 1; srcb = 2'b10; end
            StMrd:  begin mrd = 1; iord = 1; end
            StMwb:  begin rw = 1; m2r = 1; end
            StMwr:  begin mwr = 1; iord = 1; end
            StRex:  begin srca = 1; aop = 2'b10; end
            StRwb:  begin rw = 1; rdst = 1; end
            StBeq:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            StJmp:  begin pcw = 1; pcs = 2'b10; end
            StIex:  begin srca = 1; srcb = 2'b10; end
            StIwb:  begin rw = 1; end
            default: ;
         endcase
      end
      return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, pcs, illo,
              4'(st)};
   endfunction

   // Drive one cycle's inputs and, if requested, push what the outputs must be this cycle
   task automatic drive(input state_e st, input bit rdy, input logic [5:0] op, input bit r,
                        input bit chk);
      bus_if.mem_ready = rdy;
      bus_if.Op        = op;
      rst              = r;
      if (chk) begin
         exp_q.push_back(exp_vec(st, rdy, (st == StId) && !legal(op), r));
         name_q.push_back(r ? {"rst_", st.name()} : st.name());
      end
      @(posedge clk);
      #1;
   endtask

   // Instruction-level model: phase list follows from the opcode and the wait counts.
   // rst_at >= 0 asserts reset in that cycle; rand_rst allows random aborts.
   task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int rst_at,
                            input bit rand_rst);
      state_e st_l[$];
      bit     rdy_l[$];
      logic [5:0] drv_op;
      for (int k = 0; k < fw; k++) begin st_l.push_back(StIf); rdy_l.push_back(1'b0); end
      st_l.push_back(StIf); rdy_l.push_back(1'b1);
      st_l.push_back(StId); rdy_l.push_back(1'($urandom));
      if (op == 6'b100011 || op == 6'b101011) begin
         st_l.push_back(StMadr); rdy_l.push_back(1'($urandom));
         for (int k = 0; k < mw; k++) begin
            st_l.push_back(op == 6'b100011 ? StMrd : StMwr); rdy_l.push_back(1'b0);
         end
         st_l.push_back(op == 6'b100011 ? StMrd : StMwr); rdy_l.push_back(1'b1);
         if (op == 6'b100011) begin st_l.push_back(StMwb); rdy_l.push_back(1'($urandom)); end
      end else if (op == 6'b000000) begin
         st_l.push_back(StRex); rdy_l.push_back(1'($urandom));
         st_l.push_back(StRwb); rdy_l.push_back(1'($urandom));
      end else if (op == 6'b001000) begin
         st_l.push_back(StIex); rdy_l.push_back(1'($urandom));
         st_l.push_back(StIwb); rdy_l.push_back(1'($urandom));
      end else if (op == 6'b000100) begin
         st_l.push_back(StBeq); rdy_l.push_back(1'($urandom));
      end else if (op == 6'b000010) begin
         st_l.push_back(StJmp); rdy_l.push_back(1'($urandom));
      end
      foreach (st_l[i]) begin
         // Op only matters in ID/MADR; elsewhere it is scrambled to prove it is ignored
         drv_op = (st_l[i] == StId || st_l[i] == StMadr) ? op : 6'($urandom);
         if (i == rst_at || (rand_rst && i > 0 && $urandom_range(0, 40) == 0)) begin
            drive(st_l[i], 1'($urandom), drv_op, 1'b1, 1'b1);
            if ($urandom_range(0, 1) == 1) drive(StIf, 1'b1, 6'($urandom), 1'b1, 1'b1);
            return;
         end
         drive(st_l[i], rdy_l[i], drv_op, 1'b0, 1'b1);
      end
   endtask

   always @(negedge clk) begin
      logic [20:0] e, a;
      string       nm;
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         a  = {bus_if.PCWrite, bus_if.PCWriteCond, bus_if.IorD, bus_if.MemRead,
               bus_if.MemWrite, bus_if.IRWrite, bus_if.MemtoReg, bus_if.RegDst,
               bus_if.RegWrite, bus_if.ALUSrcA, bus_if.ALUSrcB, bus_if.ALUop,
               bus_if.PCSource, bus_if.illegal, bus_if.state};
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL %s @%0t: got %b expected %b", nm, $time, a, e);
         end
      end
   end

   initial begin
      logic [5:0] op;
      int         waits;
      bus_if.Op        = '0;
      bus_if.mem_ready = 1'b1;
      rst              = 1'b1;
      // Two reset cycles with mem_ready high; state is unknown during the first
      drive(StIf, 1'b1, 6'd0, 1'b1, 1'b0);
      drive(StIf, 1'b1, 6'd0, 1'b1, 1'b1);
      // Directed: lw, R-type with slow fetch, beq, illegal, sw aborted mid-wait, j, addi
      run_instr(6'b100011, 0, 0, -1, 1'b0);
      run_instr(6'b000000, 3, 0, -1, 1'b0);
      run_instr(6'b000100, 0, 0, -1, 1'b0);
      run_instr(6'b111111, 0, 0, -1, 1'b0);
      run_instr(6'b101011, 0, 3, 4, 1'b0);
      run_instr(6'b000010, 1, 0, -1, 1'b0);
      run_instr(6'b001000, 0, 0, -1, 1'b0);
      run_instr(6'b100011, 2, 2, -1, 1'b0);
      // Randomized instruction stream with occasional reset aborts
      for (int n = 0; n < 200; n++) begin
         case ($urandom_range(0, 6))
            0: op = 6'b000000;
            1: op = 6'b100011;
            2: op = 6'b101011;
            3: op = 6'b000100;
            4: op = 6'b000010;
            5: op = 6'b001000;
            default: begin
               op = 6'($urandom);
               while (legal(op)) op = 6'($urandom);
            end
         endcase
         waits = $urandom_range(0, 3);
         run_instr(op, waits, $urandom_range(0, 3), -1, 1'b1);
      end
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
